// File: rtl/wb_scr1_mem_bridge.sv
// ---------------------------------------------------------------------------
// wb_scr1_mem_bridge
// Bridges one SCR1 core memory port (IMEM or DMEM) to a Wishbone B4 classic
// master. Adds lane-aligned byte selects, sub-word write replication,
// 32/64-bit bus support, misalignment/bus-error reporting, a bus timeout and
// request acceptance in the response cycle.
//
// Ports:
//   wb_clk_i, wb_rst_n_i     clock, synchronous active-low reset
//   mem_req_i/mem_req_ack_o  core request handshake (ack is combinational)
//   mem_cmd_i                0 = read, 1 = write
//   mem_width_i              0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   mem_addr_i, mem_wdata_i  byte address, right-aligned write data
//   mem_rdata_o, mem_resp_o  raw 32-bit read word, NOTRDY/RDY_OK/RDY_ER
//   wbm_*                    Wishbone classic master (all outputs registered)
// ---------------------------------------------------------------------------
module wb_scr1_mem_bridge #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            mem_req_i,
    output logic            mem_req_ack_o,
    input  logic            mem_cmd_i,
    input  logic [1:0]      mem_width_i,
    input  logic [AW-1:0]   mem_addr_i,
    input  logic [31:0]     mem_wdata_i,
    output logic [31:0]     mem_rdata_o,
    output logic [1:0]      mem_resp_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic            wbm_stb_o,
    output logic            wbm_cyc_o,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned OB = $clog2(SW);
    // A zero TIMEOUT still needs a 1-bit counter to keep the datapath legal.
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] RESP_NOTRDY = 2'd0;
    localparam logic [1:0] RESP_OK     = 2'd1;
    localparam logic [1:0] RESP_ER     = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [1:0]    resp_q, resp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          lane_q, lane_d;

    logic          accept;
    logic          misaligned;
    logic          tmo_hit;
    logic [OB-1:0] off;
    logic [SW-1:0] sel_new;
    logic [DW-1:0] dat_new;
    logic [AW-1:0] adr_new;
    logic [31:0]   rdata_cap;

    // Requests are taken whenever no bus cycle is in flight.
    assign accept = mem_req_i & ((state_q == ST_IDLE) | (state_q == ST_RESP)) & wb_rst_n_i;
    assign mem_req_ack_o = accept;

    assign off     = mem_addr_i[OB-1:0];
    assign adr_new = {mem_addr_i[AW-1:OB], {OB{1'b0}}};

    // Bus cycle expires on the TIMEOUT-th quiet cycle; TIMEOUT = 0 never expires.
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT - 1));

    // 32-bit half of the bus word holding the addressed word (always 0 on a 32-bit bus).
    assign rdata_cap = 32'(wbm_dat_i >> {lane_q, 5'd0});

    // Alignment, byte selects and lane replication for the incoming request.
    always_comb begin
        misaligned = 1'b0;
        sel_new    = SW'(4'hF) << off;
        dat_new    = {(DW/32){mem_wdata_i}};
        case (mem_width_i)
            2'd0: begin
                sel_new = SW'(1) << off;
                dat_new = {SW{mem_wdata_i[7:0]}};
            end
            2'd1: begin
                misaligned = mem_addr_i[0];
                sel_new    = SW'(3) << off;
                dat_new    = {(DW/16){mem_wdata_i[15:0]}};
            end
            2'd2: begin
                misaligned = |mem_addr_i[1:0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        resp_d  = RESP_NOTRDY;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (misaligned) begin
                        state_d = ST_RESP;
                        resp_d  = RESP_ER;
                    end else begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = mem_cmd_i;
                        adr_d   = adr_new;
                        sel_d   = sel_new;
                        dat_d   = dat_new;
                        cnt_d   = TW'(0);
                        lane_d  = (DW == 64) ? mem_addr_i[2] : 1'b0;
                    end
                end
            end
            ST_BUS: begin
                if (wbm_err_i) begin
                    state_d = ST_RESP;
                    resp_d  = RESP_ER;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                end else if (wbm_ack_i) begin
                    state_d = ST_RESP;
                    resp_d  = RESP_OK;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = rdata_cap;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_RESP;
                    resp_d  = RESP_ER;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            resp_q  <= RESP_NOTRDY;
            rdata_q <= 32'd0;
            cnt_q   <= TW'(0);
            lane_q  <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
        end
    end

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_dat_o   = dat_q;
    assign mem_resp_o  = resp_q;
    assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_wb_scr1_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_scr1_mem_bridge
// Drives a 32-bit and a 64-bit bridge in lockstep from the same core-side
// stimulus and the same Wishbone slave model. Expected responses and bus
// payloads are derived from the transaction rules and queued at acceptance;
// a monitor pops and compares whenever a bridge presents a response or a bus
// cycle.
// ---------------------------------------------------------------------------
module tb_wb_scr1_mem_bridge;

    localparam int unsigned TMO = 4;

    localparam int M_ACK    = 0;
    localparam int M_ERR    = 1;
    localparam int M_BOTH   = 2;
    localparam int M_SILENT = 3;

    typedef struct {
        logic        cmd;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          mode;
        logic [63:0] rdata;
    } txn_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rd32;
        logic [31:0] rd64;
        int          cyc;
    } rexp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr32;
        logic [3:0]  sel32;
        logic [31:0] dat32;
        logic [31:0] adr64;
        logic [7:0]  sel64;
        logic [63:0] dat64;
    } bexp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_cmd;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        ack_s;
    logic        err_s;
    logic [63:0] sdat;

    logic        rack32, rack64;
    logic [31:0] rdata32, rdata64;
    logic [1:0]  resp32, resp64;
    logic [31:0] adr32, adr64;
    logic [31:0] dat32;
    logic [63:0] dat64;
    logic        we32, we64, stb32, stb64, cyc32, cyc64;
    logic [3:0]  sel32;
    logic [7:0]  sel64;

    int checks  = 0;
    int errors  = 0;
    int cyc_cnt = 0;

    rexp_t rq[$];
    bexp_t bq[$];
    txn_t  sq[$];

    logic [31:0] m_rd32 = 32'd0;
    logic [31:0] m_rd64 = 32'd0;

    wb_scr1_mem_bridge #(.AW(32), .DW(32), .TIMEOUT(TMO)) u_dut32 (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .mem_req_i     (mem_req),
        .mem_req_ack_o (rack32),
        .mem_cmd_i     (mem_cmd),
        .mem_width_i   (mem_width),
        .mem_addr_i    (mem_addr),
        .mem_wdata_i   (mem_wdata),
        .mem_rdata_o   (rdata32),
        .mem_resp_o    (resp32),
        .wbm_adr_o     (adr32),
        .wbm_dat_o     (dat32),
        .wbm_dat_i     (sdat[31:0]),
        .wbm_we_o      (we32),
        .wbm_sel_o     (sel32),
        .wbm_stb_o     (stb32),
        .wbm_cyc_o     (cyc32),
        .wbm_ack_i     (ack_s),
        .wbm_err_i     (err_s)
    );

    wb_scr1_mem_bridge #(.AW(32), .DW(64), .TIMEOUT(TMO)) u_dut64 (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .mem_req_i     (mem_req),
        .mem_req_ack_o (rack64),
        .mem_cmd_i     (mem_cmd),
        .mem_width_i   (mem_width),
        .mem_addr_i    (mem_addr),
        .mem_wdata_i   (mem_wdata),
        .mem_rdata_o   (rdata64),
        .mem_resp_o    (resp64),
        .wbm_adr_o     (adr64),
        .wbm_dat_o     (dat64),
        .wbm_dat_i     (sdat),
        .wbm_we_o      (we64),
        .wbm_sel_o     (sel64),
        .wbm_stb_o     (stb64),
        .wbm_cyc_o     (cyc64),
        .wbm_ack_i     (ack_s),
        .wbm_err_i     (err_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc_cnt);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_mis(input txn_t t);
        if (t.width == 2'd3) return 1'b1;
        return (t.addr % (32'd1 << t.width)) != 0;
    endfunction

    function automatic int bus_len(input txn_t t);
        if (t.mode == M_SILENT || t.waits >= int'(TMO)) return int'(TMO);
        return t.waits + 1;
    endfunction

    function automatic logic [1:0] resp_of(input txn_t t);
        if (t.mode == M_ACK && t.waits < int'(TMO)) return 2'd1;
        return 2'd2;
    endfunction

    function automatic bexp_t bus_exp(input txn_t t);
        bexp_t b;
        int sz;
        int o4;
        int o8;
        sz = 1 << t.width;
        o4 = int'(t.addr % 4);
        o8 = int'(t.addr % 8);
        b.we    = t.cmd;
        b.adr32 = (t.addr / 4) * 4;
        b.adr64 = (t.addr / 8) * 8;
        b.sel32 = '0;
        b.sel64 = '0;
        b.dat32 = '0;
        b.dat64 = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= o8 && i < o8 + sz) b.sel64[i] = 1'b1;
            b.dat64[8*i +: 8] = t.wdata[8*(i % sz) +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            if (i >= o4 && i < o4 + sz) b.sel32[i] = 1'b1;
            b.dat32[8*i +: 8] = t.wdata[8*(i % sz) +: 8];
        end
        return b;
    endfunction

    function automatic txn_t mk(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                                input logic [31:0] wd, input int waits, input int mode,
                                input logic [63:0] rd);
        txn_t t;
        t.cmd = cmd; t.width = w; t.addr = a; t.wdata = wd;
        t.waits = waits; t.mode = mode; t.rdata = rd;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        int r;
        t.cmd = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 15));
        t.width = (r == 0) ? 2'd3 : 2'(r % 3);
        t.addr = $urandom & 32'h0000_FFFF;
        if ($urandom_range(0, 4) != 0 && t.width != 2'd3)
            t.addr = t.addr & ~((32'd1 << t.width) - 32'd1);
        t.wdata = $urandom;
        t.rdata = {$urandom, $urandom};
        r = int'($urandom_range(0, 9));
        t.mode = (r < 7) ? M_ACK : (r == 7) ? M_ERR : (r == 8) ? M_BOTH : M_SILENT;
        t.waits = int'($urandom_range(0, 5));
        return t;
    endfunction

    // Present a request, wait for acceptance, queue what must come back.
    task automatic issue(input txn_t t, input int gap);
        int    n;
        bit    acc;
        bit    mis;
        int    len;
        rexp_t e;
        mem_req   = 1'b1;
        mem_cmd   = t.cmd;
        mem_width = t.width;
        mem_addr  = t.addr;
        mem_wdata = t.wdata;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 40) begin
            @(negedge clk);
            if (rack32 && rack64) acc = 1'b1;
            else n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout ack32=%0b ack64=%0b required=1 cycle=%0d", rack32, rack64, cyc_cnt);
            mem_req = 1'b0;
            @(posedge clk); #1;
            return;
        end
        mis   = is_mis(t);
        len   = mis ? 0 : bus_len(t);
        e.cyc = cyc_cnt + 1 + len;
        e.resp = mis ? 2'd2 : resp_of(t);
        if (!mis && t.cmd == 1'b0 && e.resp == 2'd1) begin
            m_rd32 = t.rdata[31:0];
            m_rd64 = ((t.addr / 4) % 2 == 1) ? t.rdata[63:32] : t.rdata[31:0];
        end
        e.rd32 = m_rd32;
        e.rd64 = m_rd64;
        rq.push_back(e);
        if (!mis) begin
            bq.push_back(bus_exp(t));
            sq.push_back(t);
        end
        @(posedge clk); #1;
        if (gap > 0) begin
            mem_req = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // ---------------- Wishbone slave ----------------
    initial begin
        txn_t cur;
        int   idx;
        bit   prev;
        cur  = mk(1'b0, 2'd0, 32'd0, 32'd0, 0, M_SILENT, 64'd0);
        idx  = 0;
        prev = 1'b0;
        ack_s = 1'b0;
        err_s = 1'b0;
        sdat  = 64'd0;
        forever begin
            @(negedge clk);
            if (cyc32) begin
                if (!prev) begin
                    if (sq.size() > 0) cur = sq.pop_front();
                    else cur = mk(1'b0, 2'd0, 32'd0, 32'd0, 0, M_SILENT, 64'd0);
                    idx = 0;
                end else begin
                    idx++;
                end
                ack_s = (cur.mode == M_ACK || cur.mode == M_BOTH) && idx == cur.waits;
                err_s = (cur.mode == M_ERR || cur.mode == M_BOTH) && idx == cur.waits;
                sdat  = cur.rdata;
            end else begin
                // Noise outside a bus cycle must be ignored by the bridge.
                ack_s = 1'($urandom);
                err_s = 1'($urandom);
                sdat  = {$urandom, $urandom};
            end
            prev = cyc32;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bexp_t b;
        rexp_t e;
        bit    prev;
        prev = 1'b0;
        b = '{we: 1'b0, adr32: '0, sel32: '0, dat32: '0, adr64: '0, sel64: '0, dat64: '0};
        forever begin
            @(negedge clk);
            if (resp32 != 2'd0 || resp64 != 2'd0) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp resp32=%0d resp64=%0d required=none cycle=%0d", resp32, resp64, cyc_cnt);
                end else begin
                    e = rq.pop_front();
                    chk("resp32", 64'(resp32), 64'(e.resp));
                    chk("resp64", 64'(resp64), 64'(e.resp));
                    chk("resp_cycle", 64'(cyc_cnt), 64'(e.cyc));
                    chk("rdata32", 64'(rdata32), 64'(e.rd32));
                    chk("rdata64", 64'(rdata64), 64'(e.rd64));
                end
            end
            if (cyc32 || cyc64) begin
                if (!prev) begin
                    if (bq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cyc cyc32=%0b cyc64=%0b required=0 cycle=%0d", cyc32, cyc64, cyc_cnt);
                    end else begin
                        b = bq.pop_front();
                    end
                end
                chk("cyc_pair", 64'({cyc32, cyc64}), 64'(2'b11));
                chk("stb_pair", 64'({stb32, stb64}), 64'(2'b11));
                chk("we32", 64'(we32), 64'(b.we));
                chk("we64", 64'(we64), 64'(b.we));
                chk("adr32", 64'(adr32), 64'(b.adr32));
                chk("adr64", 64'(adr64), 64'(b.adr64));
                chk("sel32", 64'(sel32), 64'(b.sel32));
                chk("sel64", 64'(sel64), 64'(b.sel64));
                if (b.we) begin
                    chk("dat32", 64'(dat32), 64'(b.dat32));
                    chk("dat64", dat64, b.dat64);
                end
            end
            prev = cyc32 || cyc64;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish, cycle=%0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        rst_n     = 1'b0;
        mem_req   = 1'b1;
        mem_cmd   = 1'b0;
        mem_width = 2'd2;
        mem_addr  = 32'h100;
        mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", 64'({cyc32, cyc64, stb32, stb64, we32, we64}), 64'd0);
        chk("rst_adr", 64'({adr32, adr64}), 64'd0);
        chk("rst_sel", 64'({sel32, sel64}), 64'd0);
        chk("rst_dat32", 64'(dat32), 64'd0);
        chk("rst_dat64", dat64, 64'd0);
        chk("rst_resp", 64'({resp32, resp64}), 64'd0);
        chk("rst_rdata", 64'({rdata32, rdata64}), 64'd0);
        chk("rst_req_ack", 64'({rack32, rack64}), 64'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        mem_req = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the block's intended behaviour.
        issue(mk(1'b0, 2'd2, 32'h100,  32'h0,        0, M_ACK,    64'h0BADF00D_DEADBEEF), 1);
        issue(mk(1'b1, 2'd0, 32'h203,  32'h0000_00A5, 0, M_ACK,   64'h0), 1);
        issue(mk(1'b1, 2'd1, 32'h202,  32'h0000_1234, 0, M_ACK,   64'h0), 1);
        issue(mk(1'b0, 2'd2, 32'h1004, 32'h0,        0, M_ACK,    64'h11223344_55667788), 1);
        issue(mk(1'b0, 2'd2, 32'h102,  32'h0,        0, M_ACK,    64'h0), 1);
        issue(mk(1'b0, 2'd3, 32'h100,  32'h0,        0, M_ACK,    64'h0), 1);
        issue(mk(1'b0, 2'd2, 32'h300,  32'h0,        0, M_SILENT, 64'h0), 1);
        issue(mk(1'b0, 2'd2, 32'h304,  32'h0,        0, M_BOTH,   64'hAAAA_BBBB_CCCC_DDDD), 1);
        issue(mk(1'b0, 2'd2, 32'h308,  32'h0,        2, M_ERR,    64'h0), 1);
        issue(mk(1'b0, 2'd1, 32'h30E,  32'h0,        3, M_ACK,    64'h1357_9BDF_2468_ACE0), 1);
        issue(mk(1'b0, 2'd2, 32'h310,  32'h0,        0, M_ACK,    64'h0000_0001_0000_0002), 0);
        issue(mk(1'b0, 2'd2, 32'h314,  32'h0,        0, M_ACK,    64'h0000_0003_0000_0004), 0);
        issue(mk(1'b0, 2'd2, 32'h318,  32'h0,        0, M_ACK,    64'h0000_0005_0000_0006), 1);

        for (int i = 0; i < 400; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            issue(rnd_txn(), gap);
        end
        mem_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Reset in the middle of a wait-stated bus cycle.
        issue(mk(1'b0, 2'd2, 32'h400, 32'h0, 3, M_ACK, 64'hCAFE_F00D_1234_5678), 0);
        rst_n     = 1'b0;
        mem_req   = 1'b1;
        mem_addr  = 32'h500;
        @(posedge clk);
        rq.delete();
        bq.delete();
        sq.delete();
        @(negedge clk);
        chk("midrst_cyc", 64'({cyc32, cyc64}), 64'd0);
        chk("midrst_resp", 64'({resp32, resp64}), 64'd0);
        chk("midrst_req_ack", 64'({rack32, rack64}), 64'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        mem_req = 1'b0;
        m_rd32  = 32'd0;
        m_rd64  = 32'd0;
        @(posedge clk); #1;
        issue(mk(1'b0, 2'd2, 32'h404, 32'h0, 1, M_ACK, 64'h8765_4321_0FED_CBA9), 2);
        repeat (10) @(posedge clk);
        #1;

        chk("pending_resp", 64'(rq.size()), 64'd0);
        chk("pending_bus", 64'(bq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_scr1_mem_bridge.md
# wb_scr1_mem_bridge

Parametrised bridge from one SCR1 core memory port (IMEM or DMEM) to a Wishbone B4 classic master port. It supersedes the fixed 32-bit instruction/data masters in the SCR1 Wishbone wrapper and adds several behaviours:
- address-aligned byte selects and lane replication for sub-word writes;
- 32- or 64-bit bus width;
- misalignment and bus-error reporting via `RDY_ER`;
- a bus timeout;
- back-to-back request acceptance in the response cycle.

One instance is used per core memory port.

## Interface
Parameters:
- `AW`, default 32: address width on both sides.
- `DW`, default 32: Wishbone data width; legal values are 32 and 64.
- `TIMEOUT`, default 255: maximum bus cycles to wait for ack/err. A value of 0 disables the timeout.

Ports:
- `wb_clk_i`  in  1  clock; all logic is on the rising edge.
- `wb_rst_n_i`  in  1  reset, synchronous and active-low.
- `mem_req_i`  in  1  core request.
- `mem_req_ack_o`  out  1  request accepted this cycle (combinational).
- `mem_cmd_i`  in  1  0 = read, 1 = write.
- `mem_width_i`  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- `mem_addr_i`  in  AW  byte address.
- `mem_wdata_i`  in  32  write data, right-aligned.
- `mem_rdata_o`  out  32  read data (raw 32-bit word containing the address).
- `mem_resp_o`  out  2  0 = NOTRDY, 1 = RDY_OK, 2 = RDY_ER.
- `wbm_adr_o`  out  AW  bus address, aligned to DW/8.
- `wbm_dat_o`  out  DW  write data.
- `wbm_dat_i`  in  DW  read data.
- `wbm_we_o`  out  1  write enable.
- `wbm_sel_o`  out  DW/8  byte selects.
- `wbm_stb_o`  out  1  strobe.
- `wbm_cyc_o`  out  1  cycle.
- `wbm_ack_i`  in  1  slave acknowledge.
- `wbm_err_i`  in  1  slave error.

## Operation
- The FSM has three states: IDLE, BUS and RESP.
- `mem_req_ack_o` is `mem_req_i` AND (state is IDLE or RESP) AND `wb_rst_n_i`. On an accepting edge, cmd, width, addr and wdata are latched.
- Definitions: OFF = `addr[log2(DW/8)-1:0]`; a word lane is `addr[2]` when DW = 64.
- Alignment check: a halfword needs `addr[0]` = 0; a word needs `addr[1:0]` = 0. Width 3 counts as misaligned.
  - Misaligned request: no bus cycle; the next state is RESP with RDY_ER.
  - Aligned request: the next state is BUS.
- Byte selects:
  - byte: `1 << OFF`
  - halfword: `3 << OFF`
  - word: `4'hF << OFF`
  - Selects are driven for both reads and writes.
- Write-data replication:
  - byte: replicated to all DW/8 lanes;
  - halfword: replicated to all 16-bit lanes;
  - word: replicated to all 32-bit lanes.
- `wbm_adr_o` = addr with the low log2(DW/8) bits cleared.
- In BUS, `cyc`, `stb`, `we`, `adr`, `sel` and `dat` are all registered and held stable until termination.
- Termination, evaluated on each BUS edge in priority order:
  1. `wbm_err_i` → RESP with RDY_ER;
  2. else `wbm_ack_i` → RESP with RDY_OK, capturing rdata;
  3. else timeout expiry → RESP with RDY_ER.
  - If ack and err are both high in the same cycle, err wins.
- Read-data capture: for DW = 32, `wbm_dat_i` is taken whole. For DW = 64, the 32-bit half is selected by `addr[2]`. Writes leave `mem_rdata_o` unchanged.
- In RESP, `mem_resp_o` is valid for exactly one cycle.
  - If a new request is accepted in that cycle, the next state is BUS (or RESP if it is misaligned).
  - Otherwise the next state is IDLE.
- Timeout counter:
  - width is `$clog2(TIMEOUT+1)`;
  - cleared on entry to BUS and incremented each BUS cycle without ack/err;
  - expires when the count reaches TIMEOUT-1 with no ack/err, so `cyc` is high for exactly TIMEOUT cycles.
  - With TIMEOUT = 0 the bridge waits indefinitely.
- `wbm_ack_i` and `wbm_err_i` are ignored outside BUS.

## Timing
- Reset values:
  - `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` = 0; `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o` = 0;
  - `mem_resp_o` = 0 (NOTRDY); `mem_rdata_o` = 0; state = IDLE; timeout counter = 0.
  - `mem_req_ack_o` is 0 while `wb_rst_n_i` is low.
- Reset mid-transaction: at the next edge `cyc` and `stb` drop and the state returns to IDLE. No response is issued.
- Latency for an aligned request, with acceptance at edge 0:
  - `cyc`/`stb` are high in cycle 1;
  - with a zero-wait slave (ack in cycle 1), `mem_resp_o` is valid in cycle 2 and `cyc`/`stb` are low in cycle 2;
  - each slave wait state adds 1 cycle.
- Throughput: with a zero-wait slave and a continuous `mem_req_i`, one transfer completes every 2 cycles.
- Misaligned request: RDY_ER one cycle after acceptance, with no bus activity.
- Timeout: `mem_resp_o` = RDY_ER in the cycle after the TIMEOUT-th BUS cycle.

## Test plan
- DW=32, zero-wait read of 0x100 with slave data 0xDEADBEEF:
  - `cyc`/`stb` high for 1 cycle; `sel` = 0xF; `adr` = 0x100;
  - response in cycle 2: RDY_OK with `mem_rdata_o` = 0xDEADBEEF.
- DW=32 byte write of 0xA5 to 0x203:
  - `adr` = 0x200, `sel` = 0x8, `dat` = 0xA5A5A5A5, `we` = 1.
- DW=32 halfword write to 0x202:
  - `sel` = 0xC.
- DW=64 word read of 0x1004 with slave data 0x11223344_55667788:
  - `adr` = 0x1000, `sel` = 0xF0, `mem_rdata_o` = 0x11223344.
- Misaligned word read at 0x102:
  - no `cyc`; RDY_ER in the next cycle.
- Width = 3 request:
  - same response as a misaligned request.
- TIMEOUT=4 with a silent slave:
  - `cyc` high for exactly 4 cycles, then RDY_ER.
- Same setup with ack and err high together:
  - response is RDY_ER.
- Back-to-back: 3 consecutive zero-wait reads with `mem_req_i` held high:
  - responses land in cycles 2, 4 and 6;
  - `mem_req_ack_o` is high in cycles 0, 2 and 4.
- Reset (`wb_rst_n_i` = 0) asserted during a wait-stated BUS cycle:
  - `cyc` = 0 at the next edge and `mem_resp_o` stays 0;
  - after reset release, a fresh read completes normally.
